// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the programmable synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 3;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Write channel, read channel and status group of the programmable FIFO.
interface sync_fifo_prog_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata_c
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty levels, sticky error
// flags and a selectable standard or first-word-fall-through read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2,
    parameter int unsigned FWFT       = 0
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_prog_if.slave bus
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range
        $error("sync_fifo_prog: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_ae_range
        $error("sync_fifo_prog: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  almost_full_q;
    logic                  almost_empty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_fire;
    logic                  rd_fire;

    // Acceptance uses only registered flags, so no request reaches a status output combinationally.
    assign wr_fire = bus.wr_en & ~full_q;
    assign rd_fire = bus.rd_en & ~empty_q;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_fire),
        .waddr   (wr_ptr_q),
        .wdata   (bus.wr_data),
        .raddr   (rd_ptr_q),
        .rdata_c (mem_rdata)
    );

    always_comb begin
        count_nxt = count_q;
        if (wr_fire && !rd_fire) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (rd_fire && !wr_fire) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and flags; flags follow the next count so they are exact one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'(AF_LEVEL == 0);
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_fire) begin
                rd_ptr_q  <= rd_ptr_q + ADDR_WIDTH'(1);
                rd_data_q <= mem_rdata;
            end
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end
            count_q        <= count_nxt;
            full_q         <= (count_nxt == CNT_W'(DEPTH));
            empty_q        <= (count_nxt == '0);
            almost_full_q  <= (count_nxt >= CNT_W'(AF_LEVEL));
            almost_empty_q <= (count_nxt <= CNT_W'(AE_LEVEL));
        end
    end

    assign bus.rd_data      = (MODE == FIFO_FWFT) ? mem_rdata : rd_data_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both against a queue-based reference model through a scoreboard.
module tb_sync_fifo_prog;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [DW-1:0] mq[$];        // reference contents, head at index 0
    logic [DW-1:0] exp_std[$];   // standard-mode rd_data values due, one per edge that updates it
    logic [DW-1:0] last_std;
    bit            m_ovf;
    bit            m_unf;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_std ();
    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_fwft ();

    assign if_std.wr_en    = wr_en;
    assign if_std.wr_data  = wr_data;
    assign if_std.rd_en    = rd_en;
    assign if_fwft.wr_en   = wr_en;
    assign if_fwft.wr_data = wr_data;
    assign if_fwft.rd_en   = rd_en;

    sync_fifo_prog #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
    ) u_std (
        .clk (clk), .rst (rst), .bus (if_std)
    );

    sync_fifo_prog #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .bus (if_fwft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model advances with the same edge the DUTs see.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        bit wok;
        bit rok;
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_std.delete();
            exp_std.push_back('0);
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wok = w && (mq.size() < DEPTH);
            rok = rd && (mq.size() > 0);
            if (w && !wok) m_ovf = 1'b1;
            if (rd && !rok) m_unf = 1'b1;
            if (rok) exp_std.push_back(mq.pop_front());
            if (wok) mq.push_back(d);
        end
        #1;
    endtask

    task automatic check_status(input string tag, input logic f, input logic af, input logic e,
                                input logic ae, input logic [AW:0] c, input logic ov, input logic un);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(c), 32'(n));
        chk({tag, ".full"}, 32'(f), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(e), 32'(n == 0));
        chk({tag, ".almost_full"}, 32'(af), 32'(n >= AF));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(n <= AE));
        chk({tag, ".overflow"}, 32'(ov), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(un), 32'(m_unf));
    endtask

    // Monitor: compares whatever the DUTs present against the model once per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check_status("std", if_std.full, if_std.almost_full, if_std.empty,
                             if_std.almost_empty, if_std.count, if_std.overflow, if_std.underflow);
                check_status("fwft", if_fwft.full, if_fwft.almost_full, if_fwft.empty,
                             if_fwft.almost_empty, if_fwft.count, if_fwft.overflow, if_fwft.underflow);
                if (exp_std.size() > 0) last_std = exp_std.pop_front();
                chk("std.rd_data", 32'(if_std.rd_data), 32'(last_std));
                if (mq.size() > 0) chk("fwft.rd_data", 32'(if_fwft.rd_data), 32'(mq[0]));
            end
        end
    end

    initial begin
        last_std = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        step(1'b1, 1'b0, '0, 1'b0);
        armed = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);

        // Fill 0x01..0x08 then drain.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Overflow on full, underflow on empty, then reset clears both.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(8'h40 + i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Steady state at occupancy 4 with wrap-around.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
        for (int i = 4; i < 24; i++) step(1'b0, 1'b1, DW'(8'h10 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Both requests at full, then both at empty.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // FWFT head visibility and pop.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'h5B, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-burst with wr_en held high.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(8'h20 + i), 1'b0);
        step(1'b1, 1'b1, 8'h25, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b1, 8'h34, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 600; i++) begin
            int unsigned wp;
            int unsigned rp;
            wp = ((i / 100) % 2 == 0) ? 75 : 35;
            rp = 110 - wp;
            step(1'b0, ($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp));
            if ($urandom_range(199) == 0) step(1'b1, 1'b0, '0, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO that supersedes the fixed-width lab FIFO behind the read/write channel interfaces.
- Adds configurable depth, programmable almost-full and almost-empty levels, and a selectable standard or first-word-fall-through (FWFT) read mode.
- Adds an occupancy count and sticky overflow/underflow error flags.
- Its port groups map one-to-one onto the write_if and read_if DUT modports, plus the new status signals.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- ADDR_WIDTH, 3: depth is DEPTH = 2**ADDR_WIDTH words.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_WIDTH  read word.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- On rst=1 at a clock edge:
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
  - almost_full = (AF_LEVEL==0), which is 0 for legal values.
  - Standard mode: rd_data=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored words; the next write after reset lands at address 0.
- Write acceptance: wr_fire = wr_en & ~full, evaluated on the registered full. The word is stored at mem[wr_ptr], and wr_ptr increments modulo DEPTH (natural ADDR_WIDTH wrap).
- Read acceptance: rd_fire = rd_en & ~empty, evaluated on the registered empty; rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on wr_fire only.
  - -1 on rd_fire only.
  - Unchanged when both fire or neither fires.
- Simultaneous requests:
  - Full with both wr_en and rd_en: the read fires, the write is rejected, overflow is set.
  - Empty with both: the write fires, the read is rejected, underflow is set.
  - A rejected request has no other side effect.
- Status flags are registered and derived from the next count, so they are exact in the cycle after the causing edge.
  - No combinational path from wr_en or rd_en to full, empty, almost_full, almost_empty or count.
- Sticky errors: overflow and underflow set on a rejected request and clear only on rst.
- Standard mode (FWFT=0):
  - On rd_fire, rd_data <= mem[rd_ptr]; read latency is 1 cycle after the accepting edge.
  - rd_data holds its value when there is no rd_fire.
- FWFT mode (FWFT=1):
  - rd_data always presents mem[rd_ptr] (the head word); it is valid whenever empty=0.
  - rd_en acts as an acknowledge/pop, and the next word appears the cycle after the pop.
  - rd_data is don't-care while empty.
- Write-to-read visibility: a word written at edge N raises empty=0 after N. It is readable via rd_en at edge N+1 (standard), or visible on rd_data after N (FWFT).
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble. Continuous simultaneous read and write at any fill level 1..DEPTH-1 sustains 1 word/cycle indefinitely.
- Elaboration checks: an assertion fails if AF_LEVEL or AE_LEVEL is out of its legal range.

Decomposition:
- fifo_pkg holds:
  - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e.
  - Default constants DEF_DATA_WIDTH and DEF_ADDR_WIDTH.
  - Function fifo_depth(addr_w).
- One sub-module, fifo_mem:
  - Simple dual-port array: 1 write port, 1 asynchronous read port, parameterised DATA_WIDTH/ADDR_WIDTH.
  - Top level holds pointers, count, flags and the read-mode output logic.

Test Plan:
- DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2, FWFT=0. Write 0x01..0x08 on consecutive cycles -> count 1..8; almost_empty deasserts at count 3; almost_full asserts at count 6; full=1 after the 8th write. Then 8 reads -> rd_data 0x01..0x08, each 1 cycle after its rd_en; empty=1 at end.
- Full FIFO, wr_en=1 with wr_data=0xAA for 1 cycle -> count stays 8, overflow=1 and stays 1. Then rd_en=1 on an empty FIFO -> underflow=1, count=0, rd_data unchanged. Then rst -> both flags 0.
- Fill to 4, then 20 cycles of simultaneous wr/rd with an incrementing pattern -> count held at 4, pointers wrap at least twice, read data is exactly the write stream delayed by 4 words.
- Full with simultaneous wr_en and rd_en -> read fires, count=7, overflow=1, rejected word never appears. Empty with both -> count=1, underflow=1, later read returns the written word.
- FWFT=1: write 0x5A to an empty FIFO -> rd_data=0x5A the next cycle without rd_en. Write 0x5B, pulse rd_en -> rd_data=0x5B the following cycle, count=1.
- Write 5 words, assert rst for one cycle mid-burst with wr_en still high -> count=0, empty=1. The next written word 0x33 is read back first.
